// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers.
// An owner keeps the port for up to BURST_LEN accepted words, then the port re-arbitrates.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         fifo_write_data_o,
  output logic                          fifo_write_enable_o,
  input  logic                          fifo_full_i,
  output logic [NUM_REQ-1:0]            grant_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state, state_next;
  logic [IW-1:0]        owner, owner_next;
  logic [IW-1:0]        last_owner, last_owner_next;
  logic [IW-1:0]        pick, cand;
  logic                 pick_found;
  logic [CW-1:0]        beats, beats_next;
  logic [NUM_REQ-1:0]   grant_next;
  logic                 owner_valid;
  logic                 transfer;

  // Scan from the farthest offset to the nearest so the nearest valid requester after the last owner wins.
  always_comb begin
    pick       = '0;
    cand       = '0;
    pick_found = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IW'((int'(last_owner) + i) % NUM_REQ);
      if (req_valid_i[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next          = state;
    owner_next          = owner;
    last_owner_next     = last_owner;
    beats_next          = beats;
    grant_next          = grant_o;
    req_ready_o         = '0;
    fifo_write_enable_o = 1'b0;
    fifo_write_data_o   = '0;
    owner_valid         = req_valid_i[owner];
    transfer            = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = BURST;
          owner_next = pick;
          beats_next = '0;
          grant_next = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
        end
      end
      BURST: begin
        fifo_write_data_o   = req_data_i[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
        req_ready_o[owner]  = !fifo_full_i && !rst_i;
        transfer            = owner_valid && !fifo_full_i && !rst_i;
        fifo_write_enable_o = transfer;
        if (transfer) beats_next = beats + 1'b1;
        // A full stall with valid held keeps the grant; only a completed burst or a dropped valid releases.
        if ((transfer && beats == LAST_BEAT) || !owner_valid) begin
          state_next      = IDLE;
          last_owner_next = owner;
          beats_next      = '0;
          grant_next      = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_REQ;
      beats      <= '0;
      grant_o    <= '0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_owner <= last_owner_next;
      beats      <= beats_next;
      grant_o    <= grant_next;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural round-robin/burst model.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int BL = 4;

  logic            clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   wdata;
  logic            wen, full;

  logic            rst2;
  logic [1:0]      v2, ready2, grant2;
  logic [2*DW-1:0] d2;
  logic [DW-1:0]   wdata2;
  logic            wen2;
  logic            full2;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .fifo_write_data_o(wdata), .fifo_write_enable_o(wen),
    .fifo_full_i(full), .grant_o(grant)
  );

  fifo_write_arbiter #(.NUM_REQ(2), .DATA_WIDTH(DW), .BURST_LEN(1)) dut2 (
    .clk_i(clk), .rst_i(rst2), .req_valid_i(v2), .req_data_i(d2),
    .req_ready_o(ready2), .fifo_write_data_o(wdata2), .fifo_write_enable_o(wen2),
    .fifo_full_i(full2), .grant_o(grant2)
  );

  int         errors = 0;
  int         checks = 0;
  bit         check_en = 1'b0;
  logic [11:0] seq[N];
  int         remaining[N];
  logic [N-1:0] hs;

  // Model state: owner index (-1 when idle), last owner, words accepted in the current grant.
  int m_owner, m_last, m_beats;

  int         t1_grant[9] = '{1, 1, 1, 1, 0, 1, 1, 1, 0};
  int         t1_en[9]    = '{1, 1, 1, 1, 0, 1, 1, 0, 0};
  int         t1_data[9]  = '{'h00A0, 'h00A1, 'h00A2, 'h00A3, 0, 'h00A4, 'h00A5, 0, 0};
  int         t6_grant[6] = '{1, 0, 2, 0, 1, 0};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Called at a negedge; producers advance on the handshake seen there, new inputs go out just after the next posedge.
  task automatic applyStimulus(input logic [N-1:0] mask, input logic f, input logic r);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (hs[k]) begin
        seq[k]++;
        if (remaining[k] > 0) remaining[k]--;
      end
    end
    rst  = r;
    full = f;
    for (int k = 0; k < N; k++) begin
      req_valid[k]          = mask[k] && (remaining[k] > 0);
      req_data[k*DW +: DW]  = {4'(k), seq[k]};
    end
    @(negedge clk);
  endtask

  always @(posedge clk) begin : model_update
    int o, l, b;
    bit found;
    o = m_owner;
    l = m_last;
    b = m_beats;
    if (rst) begin
      o = -1; l = N - 1; b = 0;
    end else if (o < 0) begin
      found = 1'b0;
      for (int off = 1; off <= N; off++) begin
        if (!found && req_valid[(l + off) % N]) begin
          o = (l + off) % N;
          b = 0;
          found = 1'b1;
        end
      end
    end else if (req_valid[o] && !full) begin
      b = b + 1;
      if (b == BL) begin
        l = o; o = -1; b = 0;
      end
    end else if (!req_valid[o]) begin
      l = o; o = -1; b = 0;
    end
    m_owner <= o;
    m_last  <= l;
    m_beats <= b;
  end

  always @(negedge clk) begin : compare
    logic [N-1:0]  eg, er;
    logic          ee;
    logic [DW-1:0] ed;
    if (check_en) begin
      eg = '0; er = '0; ee = 1'b0; ed = '0;
      if (m_owner >= 0) begin
        eg[m_owner] = 1'b1;
        ed = req_data[m_owner*DW +: DW];
        if (!rst && !full) begin
          er[m_owner] = 1'b1;
          ee = req_valid[m_owner];
        end
      end
      checkOutput("model_grant", 64'(grant), 64'(eg));
      checkOutput("model_ready", 64'(req_ready), 64'(er));
      checkOutput("model_enable", 64'(wen), 64'(ee));
      checkOutput("model_data", 64'(wdata), 64'(ed));
    end
  end

  task automatic startScenario();
    applyStimulus('0, 1'b0, 1'b1);
    for (int k = 0; k < N; k++) begin
      seq[k] = '0;
      remaining[k] = 0;
    end
  endtask

  initial begin
    rst = 1'b1; full = 1'b0; req_valid = '0; req_data = '0; hs = '0;
    rst2 = 1'b1; full2 = 1'b0; v2 = '0; d2 = {16'hB001, 16'hB000};
    for (int k = 0; k < N; k++) begin
      seq[k] = '0;
      remaining[k] = 0;
    end
    @(negedge clk);
    applyStimulus('0, 1'b0, 1'b1);
    check_en = 1'b1;
    checkOutput("reset_grant", 64'(grant), 64'h0);
    checkOutput("reset_enable", 64'(wen), 64'h0);
    checkOutput("reset_ready", 64'(req_ready), 64'h0);

    $display("[TB] single requester, 6 words");
    seq[0] = 12'h0A0; remaining[0] = 6;
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("t1_idle_grant", 64'(grant), 64'h0);
    for (int n = 0; n < 9; n++) begin
      applyStimulus(4'b0001, 1'b0, 1'b0);
      checkOutput("t1_grant", 64'(grant), 64'(t1_grant[n]));
      checkOutput("t1_enable", 64'(wen), 64'(t1_en[n]));
      if (t1_en[n] != 0) checkOutput("t1_data", 64'(wdata), 64'(t1_data[n]));
    end

    $display("[TB] four requesters streaming");
    startScenario();
    for (int k = 0; k < N; k++) remaining[k] = 100;
    applyStimulus(4'b1111, 1'b0, 1'b0);
    for (int n = 1; n <= 21; n++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0);
      if (n % 5 == 1) checkOutput("t2_grant_order", 64'(grant), 64'(1 << (((n - 1) / 5) % N)));
      if (n % 5 == 0) checkOutput("t2_idle_bubble", 64'(grant), 64'h0);
    end

    $display("[TB] full stall mid-burst");
    startScenario();
    remaining[2] = 4;
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      applyStimulus(4'b0100, 1'b1, 1'b0);
      checkOutput("t3_stall_grant", 64'(grant), 64'b0100);
      checkOutput("t3_stall_enable", 64'(wen), 64'h0);
      checkOutput("t3_stall_ready", 64'(req_ready), 64'h0);
    end
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("t3_resume_data", 64'(wdata), 64'h2002);
    checkOutput("t3_resume_enable", 64'(wen), 64'h1);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("t3_last_data", 64'(wdata), 64'h2003);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("t3_release", 64'(grant), 64'h0);

    $display("[TB] owner drops valid early");
    startScenario();
    remaining[1] = 2; remaining[3] = 10;
    applyStimulus(4'b1010, 1'b0, 1'b0);
    applyStimulus(4'b1010, 1'b0, 1'b0);
    checkOutput("t4_owner1", 64'(grant), 64'b0010);
    applyStimulus(4'b1010, 1'b0, 1'b0);
    applyStimulus(4'b1010, 1'b0, 1'b0);
    checkOutput("t4_drop_enable", 64'(wen), 64'h0);
    remaining[1] = 5;
    applyStimulus(4'b1010, 1'b0, 1'b0);
    checkOutput("t4_idle", 64'(grant), 64'h0);
    applyStimulus(4'b1010, 1'b0, 1'b0);
    checkOutput("t4_next_owner", 64'(grant), 64'b1000);

    $display("[TB] reset during burst");
    startScenario();
    remaining[3] = 100;
    applyStimulus(4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    remaining[0] = 100;
    applyStimulus(4'b1001, 1'b0, 1'b1);
    checkOutput("t5_rst_enable", 64'(wen), 64'h0);
    checkOutput("t5_rst_ready", 64'(req_ready), 64'h0);
    applyStimulus(4'b1001, 1'b0, 1'b0);
    checkOutput("t5_after_rst", 64'(grant), 64'h0);
    applyStimulus(4'b1001, 1'b0, 1'b0);
    checkOutput("t5_first_grant", 64'(grant), 64'b0001);

    $display("[TB] randomized traffic");
    startScenario();
    for (int k = 0; k < N; k++) remaining[k] = 1000000;
    for (int n = 0; n < 1500; n++) begin
      applyStimulus(N'($urandom), ($urandom % 4) == 0, ($urandom % 100) == 0);
    end

    $display("[TB] two requesters, burst of one");
    @(posedge clk); #1;
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0; v2 = 2'b11;
    @(negedge clk);
    checkOutput("t6_idle", 64'(grant2), 64'h0);
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("t6_grant", 64'(grant2), 64'(t6_grant[n]));
      checkOutput("t6_enable", 64'(wen2), 64'(t6_grant[n] != 0));
      if (t6_grant[n] == 1) checkOutput("t6_data", 64'(wdata2), 64'hB000);
      if (t6_grant[n] == 2) checkOutput("t6_data", 64'(wdata2), 64'hB001);
    end

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
